// File: rtl/cosh_arbiter.sv
// rtl/cosh_arbiter.sv - two-requester round-robin front end for a shared cosh engine
module cosh_arbiter #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] x0,
  input  logic [15:0] x1,
  output logic        ack0,
  output logic        ack1,
  output logic [1:0]  res_int,
  output logic [15:0] res_frac,
  output logic        res_err,
  output logic        eng_start,
  output logic [15:0] eng_x,
  input  logic        eng_done,
  input  logic [1:0]  eng_int,
  input  logic [15:0] eng_frac,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT_CYC);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_gnt;
  logic        r_last;
  logic [15:0] r_eng_x;
  logic        r_ack0;
  logic        r_ack1;
  logic [1:0]  r_res_int;
  logic [15:0] r_res_frac;
  logic        r_res_err;

  logic        w_gnt;
  logic [8:0]  w_cnt_inc;
  logic        w_timeout;

  // On a tie the requester not served last wins; a lone request wins outright.
  assign w_gnt     = (req0 & req1) ? ~r_last : req1;
  // The timeout fires on the edge where the wait counter would reach TIMEOUT_CYC.
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_timeout = (w_cnt_inc == LP_TIMEOUT);

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign res_int   = r_res_int;
  assign res_frac  = r_res_frac;
  assign res_err   = r_res_err;
  assign eng_x     = r_eng_x;
  assign eng_start = (r_state == S_START);
  assign busy      = (r_state != S_IDLE);

  // Transaction sequencer: grant, start engine, wait for done or timeout, respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_eng_x    <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_res_int  <= '0;
      r_res_frac <= '0;
      r_res_err  <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_gnt   <= w_gnt;
            r_eng_x <= w_gnt ? x1 : x0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc[7:0];
          // Done takes priority over a timeout landing on the same edge.
          if (eng_done) begin
            r_res_int  <= eng_int;
            r_res_frac <= eng_frac;
            r_res_err  <= 1'b0;
            r_ack0     <= ~r_gnt;
            r_ack1     <= r_gnt;
            r_state    <= S_RESP;
          end else if (w_timeout) begin
            r_res_int  <= '0;
            r_res_frac <= '0;
            r_res_err  <= 1'b1;
            r_ack0     <= ~r_gnt;
            r_ack1     <= r_gnt;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cosh_arbiter.md
COSH_ARBITER -- requirements
Module: cosh_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, maximum cycles spent waiting for engine done before abort (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0, req1  input  1 each  requester requests; held high until the matching ack.
REQ-005 x0, x1  input  16 each  requester operands (unsigned fraction); stable while the matching req is high.
REQ-006 ack0, ack1  output  1 each  one-cycle completion strobe to the granted requester.
REQ-007 res_int  output  2  result integer part; valid only while ack0 or ack1 is high.
REQ-008 res_frac  output  16  result fraction part; valid only while ack0 or ack1 is high.
REQ-009 res_err  output  1  result aborted by timeout; valid only while ack0 or ack1 is high.
REQ-010 eng_start  output  1  start pulse to the shared cosh/exponential engine.
REQ-011 eng_x  output  16  engine operand; held stable from eng_start until the transaction leaves WAIT.
REQ-012 eng_done  input  1  engine completion.
REQ-013 eng_int  input  2  engine integer result.
REQ-014 eng_frac  input  16  engine fraction result.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, START, WAIT, RESP; all outputs are registered or decoded from state only (no input-to-output combinational path).
REQ-017 IDLE: if req0 or req1 is high at a clock edge, grant one requester, latch its operand into eng_x, go to START; otherwise remain in IDLE.
REQ-018 Arbitration: round-robin on a 1-bit last-grant pointer; with both requests high, grant the requester not granted last; with one request high, grant it regardless of the pointer.
REQ-019 START: eng_start is high for exactly this one cycle; the next state is always WAIT; the wait counter clears to 0.
REQ-020 WAIT: counter increments each cycle; eng_done high at an edge -> latch eng_int/eng_frac, res_err=0, go to RESP.
REQ-021 WAIT: counter reaching TIMEOUT_CYC with eng_done low -> res_int=0, res_frac=0, res_err=1, go to RESP.
REQ-022 Simultaneous eng_done and timeout at the same edge: done wins (res_err=0, engine result latched).
REQ-023 RESP: exactly one cycle; assert only the ack of the granted requester with the result fields; update the pointer to the granted requester; next state is IDLE.
REQ-024 Latency: request sampled at edge k -> eng_start high in cycle k+1; eng_done sampled at edge m -> ack high in cycle m+1.
REQ-025 Requester contract: req drops at the edge ending the ack cycle, so IDLE never re-grants a completed request.
REQ-026 eng_done while in IDLE, START or RESP is ignored and has no effect on state or results.
REQ-027 req changes during START/WAIT/RESP do not alter the grant or eng_x.
REQ-028 ack0 and ack1 are never high simultaneously; eng_start is never high outside START.

Reset
REQ-029 rst high forces, asynchronously: state=IDLE, eng_start=0, eng_x=0, ack0=ack1=0, res_int=0, res_frac=0, res_err=0, busy=0, counter=0.
REQ-030 Reset pointer value is 1, so the first tie grants requester 0.
REQ-031 rst asserted mid-transaction (START/WAIT/RESP) abandons the transaction without an ack; operation resumes from IDLE on the first edge after rst falls.

Verification
REQ-032 Single request: req0=1, x0=16'h8000, eng_done 5 cycles after eng_start with int=2'b01, frac=16'h8B2F -> eng_x=16'h8000, one-cycle ack0, res_int=1, res_frac=16'h8B2F, res_err=0.
REQ-033 Tie after reset: req0=req1=1, x0=16'h1000, x1=16'h2000 -> first eng_x=16'h1000 with ack0, then eng_x=16'h2000 with ack1; no ack overlap.
REQ-034 Round-robin: serve req0 alone, then assert req0=req1 together -> req1 granted first.
REQ-035 Timeout: TIMEOUT_CYC=16, eng_done held low -> ack with res_err=1, res_int=0, res_frac=0 exactly 17 cycles after eng_start; a late eng_done in IDLE is ignored.
REQ-036 Done/timeout collision: eng_done pulsed on the timeout edge -> res_err=0, engine result returned.
REQ-037 Reset mid-WAIT: rst pulsed 3 cycles after eng_start -> no ack, busy=0 immediately; a pending req is re-granted after rst falls.
